// File: rtl/aes_round_key_gen_if.sv
// Round-key handshake bundle between the cipher round controller and the key engine.
// master: controller (start, key_in, key_ready); slave: engine (round_key, round_num, key_valid, done).
`timescale 1ns/1ps
interface aes_round_key_gen_if;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         done;

  modport master (
    output start, key_in, key_ready,
    input  round_key, round_num, key_valid, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output round_key, round_num, key_valid, done
  );
endinterface

// File: rtl/aes_round_key_gen.sv
// Iterative AES-128 key schedule: loads key_in on start, then yields round keys 0..10 over a valid/ready
// handshake (kif slave). Ports: clk, rst_n, kif; last_key/last_key_valid when AES_KEYGEN_LAST_KEY_EN is defined.
`timescale 1ns/1ps
module aes_round_key_gen (
  input  logic               clk,
  input  logic               rst_n,
  aes_round_key_gen_if.slave kif
`ifdef AES_KEYGEN_LAST_KEY_EN
  ,
  output logic [127:0]       last_key,
  output logic               last_key_valid
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Byte i of the S-box lives at bits [2047-8*i -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       state;
  logic [7:0]   rcon;
  logic [127:0] rk_q;
  logic [3:0]   rn_q;
  logic         valid_q;
  logic         done_q;
  logic [127:0] next_key;
  logic         hs;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    logic [31:0] t, n0, n1, n2;
    t  = sub_word({rk_q[23:0], rk_q[31:24]})
       ^ {rcon, 24'h0};
    n0 = rk_q[127:96] ^ t;
    n1 = rk_q[95:64]  ^ n0;
    n2 = rk_q[63:32]  ^ n1;
    next_key = {n0, n1, n2, rk_q[31:0] ^ n2};
  end

  assign hs = valid_q && kif.key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rcon    <= 8'h01;
      rk_q    <= '0;
      rn_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef AES_KEYGEN_LAST_KEY_EN
      last_key       <= '0;
      last_key_valid <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // start overrides any handshake, including the final one.
      if (kif.start) begin
        state   <= ACTIVE;
        rcon    <= 8'h01;
        rk_q    <= kif.key_in;
        rn_q    <= '0;
        valid_q <= 1'b1;
`ifdef AES_KEYGEN_LAST_KEY_EN
        last_key_valid <= 1'b0;
`endif
      end else if (state == ACTIVE && hs) begin
        if (rn_q == 4'd10) begin
          state   <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          rk_q <= next_key;
          rn_q <= rn_q + 4'd1;
          rcon <= xtime(rcon);
`ifdef AES_KEYGEN_LAST_KEY_EN
          if (rn_q == 4'd9) begin
            last_key       <= next_key;
            last_key_valid <= 1'b1;
          end
`endif
        end
      end
    end
  end

  assign kif.round_key = rk_q;
  assign kif.round_num = rn_q;
  assign kif.key_valid = valid_q;
  assign kif.done      = done_q;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Self-checking bench for aes_round_key_gen: FIPS-197 key-schedule model with a
// GF(2^8)-derived S-box, per-cycle compare, plus directed literal checks.
`timescale 1ns/1ps
module tb_aes_round_key_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic armed = 1'b0;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int hs_cnt = 0;

  aes_round_key_gen_if kif();
`ifdef AES_KEYGEN_LAST_KEY_EN
  logic [127:0] last_key;
  logic         last_key_valid;
`endif

  aes_round_key_gen dut (
    .clk(clk),
    .rst_n(rst_n),
    .kif(kif.slave)
`ifdef AES_KEYGEN_LAST_KEY_EN
    ,
    .last_key(last_key),
    .last_key_valid(last_key_valid)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  logic [7:0] sb [256];
  logic [7:0] rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
            ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sched_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t ^= {rc[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  logic [127:0] m_keys [11];
  logic         m_active = 1'b0;
  logic         m_done = 1'b0;
  logic         m_loaded = 1'b0;
  int           m_idx = 0;
  logic [127:0] m_last = '0;
  logic         m_last_v = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_done = 1'b0;
      m_loaded = 1'b0;
      m_idx = 0;
      m_last = '0;
      m_last_v = 1'b0;
    end else begin
      m_done = 1'b0;
      if (kif.start) begin
        for (int r = 0; r < 11; r++) m_keys[r] = sched_key(kif.key_in, r);
        m_idx = 0;
        m_active = 1'b1;
        m_loaded = 1'b1;
        m_last_v = 1'b0;
      end else if (m_active && kif.key_ready) begin
        if (m_idx == 10) begin
          m_active = 1'b0;
          m_done = 1'b1;
        end else begin
          m_idx++;
          if (m_idx == 10) begin
            m_last = m_keys[10];
            m_last_v = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("key_valid", 128'(kif.key_valid), 128'(m_active));
      chk("done", 128'(kif.done), 128'(m_done));
      chk("round_num", 128'(kif.round_num), 128'(m_idx));
      chk("round_key", kif.round_key, m_loaded ? m_keys[m_idx] : '0);
`ifdef AES_KEYGEN_LAST_KEY_EN
      chk("last_key_valid", 128'(last_key_valid), 128'(m_last_v));
      chk("last_key", last_key, m_last);
`endif
      if (kif.done) done_cnt++;
      if (kif.key_valid && kif.key_ready) hs_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [127:0] k);
    kif.start = 1'b1;
    kif.key_in = k;
    tick();
    kif.start = 1'b0;
    kif.key_in = '0;
  endtask

  int d0, h0;

  initial begin
    kif.start = 1'b0;
    kif.key_in = '0;
    kif.key_ready = 1'b0;
    build_sbox();
    chk("model_k1_r1", sched_key(K1, 1), K1_R1);
    chk("model_k1_r10", sched_key(K1, 10), K1_R10);
    chk("model_k2_r1", sched_key(K2, 1), K2_R1);
    tick(2);
    rst_n = 1'b1;
    armed = 1'b1;
    chk("rst_valid", 128'(kif.key_valid), 128'd0);
    chk("rst_key", kif.round_key, 128'd0);
    chk("rst_num", 128'(kif.round_num), 128'd0);
    tick();

    // full schedule, ready held high
    kif.key_ready = 1'b1;
    d0 = done_cnt;
    do_start(K1);
    chk("s1_r0", kif.round_key, K1);
    tick();
    chk("s1_r1", kif.round_key, K1_R1);
    tick();
    chk("s1_r2", kif.round_key, K1_R2);
    tick(8);
    chk("s1_num10", 128'(kif.round_num), 128'd10);
    chk("s1_r10", kif.round_key, K1_R10);
    tick();
    chk("s1_done", 128'(kif.done), 128'd1);
    chk("s1_idle", 128'(kif.key_valid), 128'd0);
    tick(2);
    chk("s1_done_cnt", 128'(done_cnt - d0), 128'd1);
`ifdef AES_KEYGEN_LAST_KEY_EN
    chk("lk_val", last_key, K1_R10);
    chk("lk_valid", 128'(last_key_valid), 128'd1);
`endif

    // ready toggling every other cycle
    d0 = done_cnt;
    h0 = hs_cnt;
    kif.key_ready = 1'b0;
    do_start(K1);
`ifdef AES_KEYGEN_LAST_KEY_EN
    chk("lk_cleared", 128'(last_key_valid), 128'd0);
`endif
    for (int i = 0; i < 26; i++) begin
      kif.key_ready = ~kif.key_ready;
      tick();
    end
    kif.key_ready = 1'b0;
    tick(2);
    chk("s2_hs", 128'(hs_cnt - h0), 128'd11);
    chk("s2_done_cnt", 128'(done_cnt - d0), 128'd1);

    // restart at round 5
    d0 = done_cnt;
    kif.key_ready = 1'b1;
    do_start(K1);
    tick(5);
    chk("s3_num5", 128'(kif.round_num), 128'd5);
    do_start(K2);
    chk("s3_r0", kif.round_key, K2);
    chk("s3_num0", 128'(kif.round_num), 128'd0);
    tick();
    chk("s3_r1", kif.round_key, K2_R1);
    tick(12);
    chk("s3_done_cnt", 128'(done_cnt - d0), 128'd1);

    // async reset at round 7
    do_start(K1);
    tick(7);
    chk("s4_num7", 128'(kif.round_num), 128'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s4_valid", 128'(kif.key_valid), 128'd0);
    chk("s4_key", kif.round_key, 128'd0);
    chk("s4_num", 128'(kif.round_num), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start(K1);
    tick();
    chk("s4_r1", kif.round_key, K1_R1);
    tick(9);
    chk("s4_r10", kif.round_key, K1_R10);
    tick(3);

    // start collides with the round-10 handshake
    d0 = done_cnt;
    do_start(K1);
    tick(10);
    chk("s5_num10", 128'(kif.round_num), 128'd10);
    do_start(K2);
    chk("s5_num0", 128'(kif.round_num), 128'd0);
    chk("s5_valid", 128'(kif.key_valid), 128'd1);
    chk("s5_nodone", 128'(kif.done), 128'd0);
    chk("s5_done_cnt", 128'(done_cnt - d0), 128'd0);
    tick(13);
    chk("s5_done_after", 128'(done_cnt - d0), 128'd1);

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
